// File: rtl/rf_seq_pkg.sv
// rf_seq_pkg: shared types for the register-file micro-sequencer.
// Holds the FSM state enum, the opcode/subcode encodings and the instruction
// field positions.
package rf_seq_pkg;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_FETCH,
        ST_DECODE,
        ST_IMM,
        ST_RD_SRC,
        ST_RD_DST,
        ST_WB,
        ST_HALT
    } state_t;

    typedef enum logic [1:0] {
        OP_LDI = 2'b00,
        OP_MOV = 2'b01,
        OP_ADD = 2'b10,
        OP_SYS = 2'b11
    } opcode_t;

    typedef enum logic [1:0] {
        SUB_NOP  = 2'b00,
        SUB_JMP  = 2'b01,
        SUB_HALT = 2'b10,
        SUB_RSVD = 2'b11
    } subcode_t;

    typedef enum logic [2:0] {
        CLS_LDI,
        CLS_MOV,
        CLS_ADD,
        CLS_NOP,
        CLS_JMP,
        CLS_HALT,
        CLS_RSVD
    } op_class_t;

    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 6;
    localparam int DST_MSB = 5;
    localparam int DST_LSB = 4;
    localparam int SRC_MSB = 3;
    localparam int SRC_LSB = 2;

    function automatic logic [3:0] reg_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rf_seq_if.sv
// rf_seq_if: program-memory handshake and register-file bus of the sequencer.
// master = sequencer side, slave = memory / register file side.
interface rf_seq_if #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8
);
    logic              prog_req;
    logic [PC_W-1:0]   prog_addr;
    logic              prog_valid;
    logic [DATA_W-1:0] prog_data;
    logic [DATA_W-1:0] rf_rdata;
    logic [1:0]        rf_addr;
    logic [3:0]        rf_ce;
    logic [DATA_W-1:0] rf_wdata;
    logic              carry;
    logic              halted;
    logic              illegal;

    modport master (
        output prog_req, prog_addr, rf_addr, rf_ce, rf_wdata, carry, halted, illegal,
        input  prog_valid, prog_data, rf_rdata
    );

    modport slave (
        input  prog_req, prog_addr, rf_addr, rf_ce, rf_wdata, carry, halted, illegal,
        output prog_valid, prog_data, rf_rdata
    );
endinterface

// File: rtl/rf_seq_decode.sv
// rf_seq_decode: combinational instruction decoder.
// Splits the instruction register into operation class, register indices and
// the state the sequencer enters after DECODE.
module rf_seq_decode
    import rf_seq_pkg::*;
(
    input  logic [7:0] ir,
    output op_class_t  op_class,
    output logic [1:0] dst,
    output logic [1:0] src,
    output state_t     next_state,
    output logic       illegal
);

    // Map the opcode (and subcode for op 11) to a class and follow-on state
    always_comb begin
        op_class   = CLS_NOP;
        next_state = ST_FETCH;
        illegal    = 1'b0;
        dst        = ir[DST_MSB:DST_LSB];
        src        = ir[SRC_MSB:SRC_LSB];
        case (ir[OP_MSB:OP_LSB])
            OP_LDI: begin
                op_class   = CLS_LDI;
                next_state = ST_IMM;
            end
            OP_MOV: begin
                op_class   = CLS_MOV;
                next_state = ST_RD_SRC;
            end
            OP_ADD: begin
                op_class   = CLS_ADD;
                next_state = ST_RD_SRC;
            end
            default: begin
                case (ir[DST_MSB:DST_LSB])
                    SUB_NOP: begin
                        op_class   = CLS_NOP;
                        next_state = ST_FETCH;
                    end
                    SUB_JMP: begin
                        op_class   = CLS_JMP;
                        next_state = ST_IMM;
                    end
                    SUB_HALT: begin
                        op_class   = CLS_HALT;
                        next_state = ST_HALT;
                    end
                    default: begin
                        op_class   = CLS_RSVD;
                        next_state = ST_FETCH;
                        illegal    = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/rf_sequencer.sv
// rf_sequencer: micro-sequencer directly upstream of the 4x8-bit register file.
// Fetches and executes LDI/MOV/ADD/NOP/JMP/HALT one instruction at a time.
// Build macro RF_SEQ_SINGLE_STEP_EN adds a 'step' input; each latched step
// pulse releases exactly one instruction fetch.
module rf_sequencer
    import rf_seq_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0
) (
    input  logic clk,
    input  logic rst_n,
`ifdef RF_SEQ_SINGLE_STEP_EN
    input  logic step,
`endif
    rf_seq_if.master bus
);

    state_t            state;
    state_t            state_next;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] tmp;
    logic [DATA_W-1:0] res;
    logic              carry_q;

    op_class_t         op_class;
    logic [1:0]        dst;
    logic [1:0]        src;
    state_t            dec_next;
    logic              dec_illegal;

    logic              fetch_go;
    logic              prog_req;
    logic [PC_W-1:0]   prog_addr;
    logic              prog_accept;
    logic [1:0]        rf_addr;
    logic [3:0]        rf_ce;
    logic              halted;
    logic              illegal;

    rf_seq_decode u_decode (
        .ir         (ir[7:0]),
        .op_class   (op_class),
        .dst        (dst),
        .src        (src),
        .next_state (dec_next),
        .illegal    (dec_illegal)
    );

    assign prog_accept = prog_req && bus.prog_valid;

`ifdef RF_SEQ_SINGLE_STEP_EN
    logic step_pending;

    // Latch step pulses (one pending at most); a fetch handshake consumes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_pending <= 1'b0;
        end else if (state != ST_HALT) begin
            step_pending <= (step_pending && !((state == ST_FETCH) && prog_accept)) || step;
        end
    end

    assign fetch_go = step_pending;
`else
    assign fetch_go = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection; memory states hold until the handshake completes
    always_comb begin
        state_next = state;
        case (state)
            ST_BOOT:   state_next = ST_FETCH;
            ST_FETCH:  if (prog_accept) state_next = ST_DECODE;
            ST_DECODE: state_next = dec_next;
            ST_IMM: begin
                if (prog_accept) begin
                    state_next = (op_class == CLS_LDI) ? ST_WB : ST_FETCH;
                end
            end
            ST_RD_SRC: state_next = (op_class == CLS_MOV) ? ST_WB : ST_RD_DST;
            ST_RD_DST: state_next = ST_WB;
            ST_WB:     state_next = ST_FETCH;
            ST_HALT:   state_next = ST_HALT;
            default:   state_next = ST_BOOT;
        endcase
    end

    // Outputs decoded purely from registered state, ir and pc
    always_comb begin
        prog_req  = 1'b0;
        prog_addr = '0;
        rf_addr   = 2'd0;
        rf_ce     = 4'd0;
        halted    = 1'b0;
        illegal   = 1'b0;
        case (state)
            ST_FETCH: begin
                prog_req  = fetch_go;
                prog_addr = pc;
            end
            ST_IMM: begin
                prog_req  = 1'b1;
                prog_addr = pc;
            end
            ST_DECODE: illegal = dec_illegal;
            ST_RD_SRC: rf_addr = src;
            ST_RD_DST: rf_addr = dst;
            ST_WB: begin
                rf_addr = dst;
                rf_ce   = reg_onehot(dst);
            end
            ST_HALT:   halted = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers: pc, instruction, operand latch, result and carry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= PC_W'(RESET_PC);
            ir      <= '0;
            tmp     <= '0;
            res     <= '0;
            carry_q <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (prog_accept) begin
                        ir <= bus.prog_data;
                        pc <= pc + PC_W'(1);
                    end
                end
                ST_IMM: begin
                    if (prog_accept) begin
                        if (op_class == CLS_LDI) begin
                            res <= bus.prog_data;
                            pc  <= pc + PC_W'(1);
                        end else begin
                            pc  <= PC_W'(bus.prog_data);
                        end
                    end
                end
                ST_RD_SRC: begin
                    tmp <= bus.rf_rdata;
                    if (op_class == CLS_MOV) begin
                        res <= bus.rf_rdata;
                    end
                end
                ST_RD_DST: begin
                    {carry_q, res} <= {1'b0, bus.rf_rdata} + {1'b0, tmp};
                end
                default: ;
            endcase
        end
    end

    assign bus.prog_req  = prog_req;
    assign bus.prog_addr = prog_addr;
    assign bus.rf_addr   = rf_addr;
    assign bus.rf_ce     = rf_ce;
    assign bus.rf_wdata  = res;
    assign bus.carry     = carry_q;
    assign bus.halted    = halted;
    assign bus.illegal   = illegal;

endmodule

// File: tb/tb_rf_sequencer.sv
// tb_rf_sequencer: scoreboard bench for rf_sequencer.
// An instruction-level model predicts register writes and illegal pulses;
// a monitor compares them as the DUT produces them. Works with or without
// RF_SEQ_SINGLE_STEP_EN (step is held high when present).
`timescale 1ns/1ps
module tb_rf_sequencer;

    typedef struct {
        bit         is_illegal;
        logic [1:0] rd;
        logic [7:0] data;
        logic       carry;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rf_seq_if #(.DATA_W(8), .PC_W(8)) bus ();

`ifdef RF_SEQ_SINGLE_STEP_EN
    logic step = 1'b1;
`endif

    rf_sequencer #(.DATA_W(8), .PC_W(8), .RESET_PC(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef RF_SEQ_SINGLE_STEP_EN
        .step  (step),
`endif
        .bus   (bus)
    );

    logic [7:0] mem [256];
    logic [7:0] rf_regs [4];
    logic [7:0] rf_init [4];
    logic       rf_load = 1'b0;
    ev_t        exp_q [$];
    ev_t        ev;
    int         n_compared = 0;
    int         n_mismatched = 0;
    int         max_wait = 0;
    bit         rand_wait = 1'b0;
    int         wait_cnt = 0;
    bit         waiting = 1'b0;
    logic [7:0] held_addr = 8'd0;

    // Register file model: combinational read, write on one-hot enable
    assign bus.rf_rdata = rf_regs[bus.rf_addr];

    always @(posedge clk) begin
        if (rf_load) begin
            for (int k = 0; k < 4; k++) rf_regs[k] <= rf_init[k];
        end else begin
            for (int k = 0; k < 4; k++) if (bus.rf_ce[k]) rf_regs[k] <= bus.rf_wdata;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Instruction-level reference: walks program memory, queues expected events
    function automatic bit run_model(input int max_instr);
        logic [7:0] r [4];
        logic [7:0] pc, ins, imm;
        logic [1:0] d, s;
        logic       c;
        int         sum;
        for (int k = 0; k < 4; k++) r[k] = rf_init[k];
        pc = 8'd0;
        c  = 1'b0;
        for (int n = 0; n < max_instr; n++) begin
            ins = mem[pc];
            pc  = pc + 8'd1;
            d   = ins[5:4];
            s   = ins[3:2];
            case (ins[7:6])
                2'd0: begin
                    imm  = mem[pc];
                    pc   = pc + 8'd1;
                    r[d] = imm;
                    exp_q.push_back('{1'b0, d, imm, c});
                end
                2'd1: begin
                    r[d] = r[s];
                    exp_q.push_back('{1'b0, d, r[d], c});
                end
                2'd2: begin
                    sum  = int'(r[d]) + int'(r[s]);
                    c    = (sum > 255);
                    r[d] = 8'(sum);
                    exp_q.push_back('{1'b0, d, r[d], c});
                end
                default: begin
                    case (d)
                        2'd1: pc = mem[pc];
                        2'd2: return 1'b1;
                        2'd3: exp_q.push_back('{1'b1, 2'd0, 8'd0, c});
                        default: ;
                    endcase
                end
            endcase
        end
        return 1'b0;
    endfunction

    // Program memory: answers requests after a wait, injects stray valids when idle
    initial begin
        bus.prog_valid = 1'b0;
        bus.prog_data  = 8'd0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.prog_req) begin
                if (waiting) check_output("prog_addr stable", bus.prog_addr, held_addr);
                if (wait_cnt == 0) begin
                    bus.prog_valid = 1'b1;
                    bus.prog_data  = mem[bus.prog_addr];
                    waiting        = 1'b0;
                    wait_cnt       = rand_wait ? int'($urandom_range(max_wait, 0)) : max_wait;
                end else begin
                    bus.prog_valid = 1'b0;
                    bus.prog_data  = 8'($urandom);
                    waiting        = 1'b1;
                    held_addr      = bus.prog_addr;
                    wait_cnt       = wait_cnt - 1;
                end
            end else begin
                bus.prog_valid = ($urandom_range(3, 0) == 0);
                bus.prog_data  = 8'($urandom);
                waiting        = 1'b0;
            end
        end
    end

    // Monitor: every write or illegal pulse must match the head of the queue
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && (bus.rf_ce != 4'd0 || bus.illegal)) begin
                if (exp_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL unexpected event: rf_ce=%b illegal=%b, expected none", bus.rf_ce, bus.illegal);
                end else begin
                    ev = exp_q.pop_front();
                    if (ev.is_illegal) begin
                        check_output("illegal pulse", bus.illegal, 1);
                        check_output("rf_ce on illegal", bus.rf_ce, 0);
                    end else begin
                        check_output("rf_ce", bus.rf_ce, 4'b0001 << ev.rd);
                        check_output("rf_addr", bus.rf_addr, ev.rd);
                        check_output("rf_wdata", bus.rf_wdata, ev.data);
                        check_output("carry", bus.carry, ev.carry);
                        check_output("illegal during wb", bus.illegal, 0);
                    end
                end
            end
        end
    end

    task automatic fill_mem(input logic [7:0] b);
        for (int i = 0; i < 256; i++) mem[i] = b;
    endtask

    task automatic start_run(input int wait_cycles, input bit rnd);
        rst_n     = 1'b0;
        max_wait  = wait_cycles;
        rand_wait = rnd;
        wait_cnt  = rnd ? int'($urandom_range(wait_cycles, 0)) : wait_cycles;
        for (int k = 0; k < 4; k++) rf_init[k] = 8'($urandom);
        rf_load = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rf_load = 1'b0;
    endtask

    task automatic apply_stimulus(input string name, input int max_instr, input int wait_cycles, input bit rnd);
        bit model_halted;
        int cyc;
        start_run(wait_cycles, rnd);
        model_halted = run_model(max_instr);
        check_output({name, " reset prog_req"}, bus.prog_req, 0);
        check_output({name, " reset rf_ce"}, bus.rf_ce, 0);
        check_output({name, " reset halted"}, bus.halted, 0);
        rst_n = 1'b1;
        cyc = 0;
        while (cyc < 4000 && !(exp_q.size() == 0 && (!model_halted || bus.halted))) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 4000) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL %s timeout: %0d events outstanding, expected 0", name, exp_q.size());
        end
        check_output({name, " halted"}, bus.halted, model_halted);
        if (model_halted) begin
            repeat (2) @(negedge clk);
            #1;
            check_output({name, " halt prog_req"}, bus.prog_req, 0);
            check_output({name, " halt rf_ce"}, bus.rf_ce, 0);
        end
        rst_n = 1'b0;
    endtask

    // Reset while an ADD sits in RD_DST: no write escapes, restart at RESET_PC
    task automatic reset_mid_add();
        int cyc;
        fill_mem(8'hE0);
        mem[0] = 8'h00; mem[1] = 8'hF0;
        mem[2] = 8'h10; mem[3] = 8'h20;
        mem[4] = 8'h84;
        start_run(0, 1'b0);
        void'(run_model(2));
        rst_n = 1'b1;
        cyc = 0;
        while (cyc < 200 && exp_q.size() != 0) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check_output("midrst writes drained", exp_q.size(), 0);
        repeat (4) @(negedge clk);
        #1;
        check_output("midrst rd_dst rf_addr", bus.rf_addr, 0);
        rst_n = 1'b0;
        #1;
        check_output("midrst rf_ce", bus.rf_ce, 0);
        check_output("midrst rf_wdata", bus.rf_wdata, 0);
        check_output("midrst prog_req", bus.prog_req, 0);
        check_output("midrst carry", bus.carry, 0);
        repeat (3) begin
            @(negedge clk);
            check_output("midrst rf_ce held", bus.rf_ce, 0);
        end
        check_output("midrst r0 kept", rf_regs[0], 8'hF0);
        exp_q.delete();
        rst_n = 1'b1;
        cyc = 0;
        while (cyc < 20 && !bus.prog_req) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check_output("midrst first prog_req", bus.prog_req, 1);
        check_output("midrst first prog_addr", bus.prog_addr, 0);
        rst_n = 1'b0;
    endtask

    initial begin
        $display("[TB] rf_sequencer scoreboard bench start");

        fill_mem(8'hE0);
        mem[0] = 8'h20; mem[1] = 8'h5A; mem[2] = 8'hE0;
        apply_stimulus("ldi_halt", 50, 0, 1'b0);

        fill_mem(8'hE0);
        mem[0] = 8'h00; mem[1] = 8'hF0;
        mem[2] = 8'h10; mem[3] = 8'h20;
        mem[4] = 8'h84; mem[5] = 8'h94;
        apply_stimulus("add_carry", 50, 0, 1'b0);
        apply_stimulus("add_wait3", 50, 3, 1'b0);

        fill_mem(8'hE0);
        mem[0] = 8'h11; mem[1] = 8'h22;
        mem[2] = 8'hD0; mem[3] = 8'hFF;
        mem[8'hFF] = 8'h30;
        apply_stimulus("jmp_wrap", 50, 0, 1'b0);

        fill_mem(8'hE0);
        mem[0] = 8'hF0; mem[1] = 8'h20; mem[2] = 8'h77;
        apply_stimulus("reserved_op", 50, 0, 1'b0);

        fill_mem(8'hE0);
        mem[0] = 8'h00; mem[1] = 8'h33;
        mem[2] = 8'h6C; mem[3] = 8'hC0;
        mem[4] = 8'hB8;
        apply_stimulus("mov_nop_add", 50, 1, 1'b1);

        reset_mid_add();

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            apply_stimulus("random", 40, 3, 1'b1);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
